// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction fetch requester with prefetch queue and branch redirect
module if_fetch_unit #(
    parameter int          ADDR_W   = 32,
    parameter int          INST_W   = 32,
    parameter int          DEPTH    = 2,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              rom_ce_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_data_i,
    input  logic              branch_flag_i,
    input  logic [ADDR_W-1:0] branch_target_address_i,
    input  logic              id_ready_i,
    output logic              id_valid_o,
    output logic [ADDR_W-1:0] id_pc_o,
    output logic [INST_W-1:0] id_inst_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic              rom_ce;
    logic [ADDR_W-1:0] fetch_pc;
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [INST_W-1:0] inst_mem [DEPTH];

    logic pop;
    logic push;

    assign id_valid_o = (count != '0);
    assign pop        = id_valid_o & id_ready_i;
    // A full queue still fetches when the head leaves in the same cycle.
    assign push       = rom_ce & ((count < CW'(DEPTH)) | pop) & ~branch_flag_i;

    assign rom_ce_o   = rom_ce;
    assign rom_addr_o = rom_ce ? fetch_pc : '0;
    assign id_pc_o    = id_valid_o ? pc_mem[head]   : '0;
    assign id_inst_o  = id_valid_o ? inst_mem[head] : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            rom_ce   <= 1'b0;
            fetch_pc <= ADDR_W'(RESET_PC);
            head     <= '0;
            tail     <= '0;
            count    <= '0;
        end else begin
            rom_ce <= 1'b1;
            if (branch_flag_i) begin
                // Flush wins over any pop: the head is dropped, not consumed.
                fetch_pc <= branch_target_address_i & ~ADDR_W'(3);
                head     <= '0;
                tail     <= '0;
                count    <= '0;
            end else begin
                if (push) begin
                    tail     <= tail + PW'(1);
                    fetch_pc <= fetch_pc + ADDR_W'(4);
                end
                if (pop) begin
                    head <= head + PW'(1);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (pop && !push) begin
                    count <= count - CW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) begin
            pc_mem[tail]   <= fetch_pc;
            inst_mem[tail] <= rom_data_i;
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - randomized and directed checks of if_fetch_unit against a queue model
module tb_if_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        branch = 1'b0;
    logic [31:0] target = '0;
    logic        ready = 1'b0;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;

    logic        rst1 = 1'b1;
    logic        rom_ce1;
    logic [31:0] rom_addr1;
    logic [31:0] rom_data1;
    logic        id_valid1;
    logic [31:0] id_pc1;
    logic [31:0] id_inst1;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    assign rom_data  = rom_word(rom_addr);
    assign rom_data1 = rom_word(rom_addr1);

    if_fetch_unit #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
        .clk(clk), .rst(rst),
        .rom_ce_o(rom_ce), .rom_addr_o(rom_addr), .rom_data_i(rom_data),
        .branch_flag_i(branch), .branch_target_address_i(target),
        .id_ready_i(ready), .id_valid_o(id_valid), .id_pc_o(id_pc), .id_inst_o(id_inst)
    );

    if_fetch_unit #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk(clk), .rst(rst1),
        .rom_ce_o(rom_ce1), .rom_addr_o(rom_addr1), .rom_data_i(rom_data1),
        .branch_flag_i(1'b0), .branch_target_address_i(32'h0),
        .id_ready_i(1'b1), .id_valid_o(id_valid1), .id_pc_o(id_pc1), .id_inst_o(id_inst1)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        mq[$];
    logic        m_ce;
    logic [31:0] m_pc;
    int          n_checks = 0;
    int          n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: a FIFO of (pc, word) pairs plus the next fetch address.
    task automatic model_update(input logic r, input logic b, input logic [31:0] t, input logic rd);
        bit do_pop;
        bit do_push;
        if (r) begin
            m_ce = 1'b0;
            m_pc = 32'h0;
            mq.delete();
        end else begin
            do_pop = (mq.size() > 0) && rd;
            if (b) begin
                mq.delete();
                m_pc = {t[31:2], 2'b00};
            end else begin
                do_push = m_ce && ((mq.size() < DEPTH) || do_pop);
                if (do_pop) void'(mq.pop_front());
                if (do_push) begin
                    mq.push_back('{pc: m_pc, inst: rom_word(m_pc)});
                    m_pc = m_pc + 32'd4;
                end
            end
            m_ce = 1'b1;
        end
    endtask

    task automatic check_all();
        chk("rom_ce", {31'b0, rom_ce}, {31'b0, m_ce});
        chk("rom_addr", rom_addr, m_ce ? m_pc : 32'h0);
        chk("id_valid", {31'b0, id_valid}, {31'b0, mq.size() > 0});
        chk("id_pc", id_pc, (mq.size() > 0) ? mq[0].pc : 32'h0);
        chk("id_inst", id_inst, (mq.size() > 0) ? mq[0].inst : 32'h0);
    endtask

    task automatic step(input logic r, input logic b, input logic [31:0] t, input logic rd);
        rst = r; branch = b; target = t; ready = rd;
        model_update(r, b, t, rd);
        @(posedge clk);
        #1;
        check_all();
    endtask

    logic [31:0] wrap_exp [4];

    initial begin
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        wrap_exp[3] = 32'h0000_0004;

        // Streaming with decode always ready.
        step(1, 0, 0, 1);
        step(1, 0, 0, 1);
        chk("reset_ce", {31'b0, rom_ce}, 32'h0);
        chk("reset_pc_out", id_pc, 32'h0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // Backpressure fills the queue and holds the fetch address.
        step(1, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
        chk("full_hold_addr", rom_addr, 32'h8);
        chk("full_head_pc", id_pc, 32'h0);
        for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

        // Branch out of a full queue to a misaligned target.
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 32'h43, 0);
        chk("br_valid", {31'b0, id_valid}, 32'h0);
        chk("br_addr", rom_addr, 32'h40);
        step(0, 0, 0, 0);
        chk("br_head_pc", id_pc, 32'h40);
        chk("br_head_inst", id_inst, 32'h1010);

        // Branch with ready high while head is pc 8: head is dropped.
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        chk("pre_br_head", id_pc, 32'h8);
        step(0, 1, 32'h100, 1);
        step(0, 0, 0, 1);
        chk("post_br_head", id_pc, 32'h100);

        // Reset mid-operation with two entries queued at 0x20.
        step(0, 1, 32'h20, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("q_pc20", id_pc, 32'h20);
        step(1, 0, 0, 0);
        chk("rst_mid_ce", {31'b0, rom_ce}, 32'h0);
        chk("rst_mid_valid", {31'b0, id_valid}, 32'h0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) == 0),
                 $urandom, $urandom_range(0, 1) != 0);
        end

        // Fetch address wrap on the second instance.
        rst1 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("wrap_addr%0d", k), rom_addr1, wrap_exp[k]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
